aes_stream_loader: RTL and testbench

Streaming front/back end for the unrolled AES-128 encryption core. It accepts key and plaintext as 32-bit words over a valid/ready input stream and assembles them into stable 128-bit `Mes`/`Key` operands that drive the core. It waits out the core's fixed pipeline latency, then captures the 128-bit ciphertext. The ciphertext is returned as four 32-bit words over a valid/ready output stream.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/word_packer.sv | 22 ++
 rtl/aes_stream_loader.sv | 97 +++++++++
 tb/tb_aes_stream_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 stream loader: loader states,
// block geometry and MS-first word selection.
package aes_pkg;

  localparam int AES_WORDS   = 4;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_MES,
    WAIT,
    DRAIN
  } loader_state_e;

  // Word 0 is the most-significant 32 bits of the block.
  function automatic logic [31:0] block_word(input logic [AES_BLOCK_W-1:0] blk,
                                             input logic [1:0] n);
    return blk[(AES_WORDS - 1 - int'(n)) * 32 +: 32];
  endfunction

endpackage

// File: rtl/word_packer.sv
// Four-word operand register for the AES core: words are written in by index
// (word 0 lands in the top 32 bits) and the whole block is presented at once.
module word_packer
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [1:0]             wr_idx,
  input  logic [31:0]            wr_data,
  output logic [AES_BLOCK_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (clear) begin
      data <= '0;
    end else if (wr_en) begin
      data[(AES_WORDS - 1 - int'(wr_idx)) * 32 +: 32] <= wr_data;
    end
  end

endmodule

// File: rtl/aes_stream_loader.sv
// Valid/ready word-stream front/back end for the unrolled AES-128 core.
// Optional key reuse between frames is enabled by defining AES_LOADER_KEY_REUSE_EN.
module aes_stream_loader
  import aes_pkg::*;
#(
  parameter int CORE_LATENCY = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
`ifdef AES_LOADER_KEY_REUSE_EN
  input  logic                   key_keep,
`endif
  output logic [AES_BLOCK_W-1:0] core_mes,
  output logic [AES_BLOCK_W-1:0] core_key,
  input  logic [AES_BLOCK_W-1:0] core_result,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam logic [5:0] LAT_LAST = 6'(CORE_LATENCY - 1);

  loader_state_e          state, state_next;
  logic [1:0]             word_cnt;
  logic [5:0]             lat_cnt;
  logic [AES_BLOCK_W-1:0] res_q;
  logic                   in_fire, out_fire, lat_done, last_word;

  // Handshake outputs decode from state alone, never from in_valid/out_ready.
  assign in_ready  = (state == LOAD_KEY) || (state == LOAD_MES);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != LOAD_KEY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_word = (word_cnt == 2'd3);
  assign lat_done  = (state == WAIT) && (lat_cnt == LAT_LAST);
  assign out_data  = block_word(res_q, word_cnt);

  always_comb begin
    state_next = state;
    case (state)
      LOAD_KEY: if (in_fire && last_word) state_next = LOAD_MES;
      LOAD_MES: if (in_fire && last_word) state_next = WAIT;
      WAIT:     if (lat_done) state_next = DRAIN;
      DRAIN: begin
        if (out_fire && last_word) begin
`ifdef AES_LOADER_KEY_REUSE_EN
          state_next = key_keep ? LOAD_MES : LOAD_KEY;
`else
          state_next = LOAD_KEY;
`endif
        end
      end
      default:  state_next = LOAD_KEY;
    endcase
  end

  // word_cnt wraps 3->0 on the same transfer that changes state, so each
  // phase starts from word 0; lat_cnt only runs while waiting on the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD_KEY;
      word_cnt <= '0;
      lat_cnt  <= '0;
      res_q    <= '0;
    end else begin
      state <= state_next;
      if (in_fire || out_fire) word_cnt <= word_cnt + 2'd1;
      if (state == WAIT) lat_cnt <= lat_cnt + 6'd1;
      else               lat_cnt <= '0;
      if (lat_done) res_q <= core_result;
    end
  end

  word_packer u_key_packer (
    .clk     (clk),
    .clear   (reset),
    .wr_en   (in_fire && (state == LOAD_KEY)),
    .wr_idx  (word_cnt),
    .wr_data (in_data),
    .data    (core_key)
  );

  word_packer u_mes_packer (
    .clk     (clk),
    .clear   (reset),
    .wr_en   (in_fire && (state == LOAD_MES)),
    .wr_idx  (word_cnt),
    .wr_data (in_data),
    .data    (core_mes)
  );

endmodule

// File: tb/tb_aes_stream_loader.sv
// Self-checking bench for aes_stream_loader with a behavioural AES-128 core
// model behind a fixed-latency delay line.
module tb_aes_stream_loader;

  localparam int LAT = 20;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_ready = 1'b0;
  logic [127:0] core_mes, core_key, core_result;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         busy;
`ifdef AES_LOADER_KEY_REUSE_EN
  logic         key_keep = 1'b0;
`endif

  int checks = 0;
  int fails = 0;
  int words_accepted = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] pipe [LAT-1];

  always #5 clk = ~clk;

  aes_stream_loader #(.CORE_LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
`ifdef AES_LOADER_KEY_REUSE_EN
    .key_keep    (key_keep),
`endif
    .core_mes    (core_mes),
    .core_key    (core_key),
    .core_result (core_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  // ---------------- behavioural AES-128 ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   st [16];
    logic [7:0]   sh [16];
    logic [127:0] blk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    blk = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_t[blk[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) sh[rr + 4*c] = st[rr + 4*((c + rr) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = sh[4*c]; a1 = sh[4*c+1]; a2 = sh[4*c+2]; a3 = sh[4*c+3];
          sh[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          sh[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          sh[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          sh[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = sh[i];
      blk = blk ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return blk;
  endfunction

  // Core model: result of the operands present LAT cycles earlier.
  always @(posedge clk) begin
    pipe[0] <= aes_encrypt(core_key, core_mes);
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign core_result = pipe[LAT-2];

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends words first..first+count-1 of {key, plaintext}, MS word first.
  task automatic send_words(input logic [255:0] frame, input int first, input int count,
                            input int max_gap, output bit ok);
    bit sent;
    ok = 1'b1;
    for (int i = first; i < first + count; i++) begin
      repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) step();
      sent = 1'b0;
      for (int k = 0; k < 200 && !sent; k++) begin
        if (in_ready === 1'b1) begin
          in_data  = frame[255 - 32*i -: 32];
          in_valid = 1'b1;
          step();
          in_valid = 1'b0;
          words_accepted++;
          sent = 1'b1;
        end else begin
          step();
        end
      end
      if (!sent) ok = 1'b0;
    end
  endtask

  // Called in the cycle after the final message word; collects four output words.
  task automatic recv_block(input logic [127:0] exp_key, input logic [127:0] exp_mes,
                            input int stall_word, output logic [127:0] got,
                            output int first_valid, output bit ready_low,
                            output bit operands_stable, output bit stall_stable, output bit ok);
    logic [31:0] held;
    ok = 1'b1; ready_low = 1'b1; operands_stable = 1'b1; stall_stable = 1'b1;
    got = '0; first_valid = 1; out_ready = 1'b0;
    while (out_valid !== 1'b1 && first_valid <= 200) begin
      if (in_ready !== 1'b0) ready_low = 1'b0;
      if (core_key !== exp_key || core_mes !== exp_mes) operands_stable = 1'b0;
      step();
      first_valid++;
    end
    if (out_valid !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    for (int n = 0; n < 4; n++) begin
      if (n == stall_word) begin
        held = out_data;
        repeat (5) begin
          step();
          if (out_data !== held || out_valid !== 1'b1) stall_stable = 1'b0;
          if (in_ready !== 1'b0) ready_low = 1'b0;
        end
      end
      if (out_valid !== 1'b1) ok = 1'b0;
      if (in_ready !== 1'b0) ready_low = 1'b0;
      if (core_key !== exp_key || core_mes !== exp_mes) operands_stable = 1'b0;
      got[127 - 32*n -: 32] = out_data;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL reset_flags: got ready/valid/busy=%b expected 100", {in_ready, out_valid, busy});
    end
    checks++;
    if (out_data !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
    end
    checks++;
    if (core_key !== '0 || core_mes !== '0) begin
      fails++;
      $display("[TB] FAIL reset_operands: got key %h mes %h expected 0", core_key, core_mes);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_fips();
    bit ok, rl, os, ss;
    int fv;
    logic [127:0] got;
    send_words({FIPS_KEY, FIPS_PT}, 0, 8, 0, ok);
    checks++;
    if (!ok) begin fails++; $display("[TB] FAIL fips_input: words not accepted"); end
    recv_block(FIPS_KEY, FIPS_PT, -1, got, fv, rl, os, ss, ok);
    checks++;
    if (!ok) begin fails++; $display("[TB] FAIL fips_out_timeout: out_valid not seen"); end
    checks++;
    if (got !== FIPS_CT) begin fails++; $display("[TB] FAIL fips_data: got %h expected %h", got, FIPS_CT); end
    checks++;
    if (fv != LAT + 1) begin fails++; $display("[TB] FAIL fips_latency: got %0d expected %0d", fv, LAT + 1); end
    checks++;
    if (!rl) begin fails++; $display("[TB] FAIL fips_in_ready: got high during WAIT/DRAIN expected low"); end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL fips_reload: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_stalls();
    bit ok, rl, os, ss;
    int fv;
    logic [127:0] got;
    send_words({FIPS_KEY, FIPS_PT}, 0, 8, 3, ok);
    recv_block(FIPS_KEY, FIPS_PT, int'($urandom_range(0, 3)), got, fv, rl, os, ss, ok);
    checks++;
    if (!ok || got !== FIPS_CT) begin
      fails++;
      $display("[TB] FAIL stall_data: got %h ok=%0d expected %h", got, ok, FIPS_CT);
    end
    checks++;
    if (!ss) begin fails++; $display("[TB] FAIL stall_hold: got out_data/out_valid changing expected stable"); end
    checks++;
    if (!rl) begin fails++; $display("[TB] FAIL stall_in_ready: got high during WAIT/DRAIN expected low"); end
  endtask

  task automatic test_mid_reset();
    bit ok, rl, os, ss;
    int fv;
    logic [127:0] got;
    send_words({FIPS_KEY, FIPS_PT}, 0, 5, 1, ok);
    reset = 1'b1;
    step();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'h0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: got rvb=%b data=%h expected 100 0",
               {in_ready, out_valid, busy}, out_data);
    end
    checks++;
    if (core_key !== '0 || core_mes !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_operands: got key %h mes %h expected 0", core_key, core_mes);
    end
    reset = 1'b0;
    send_words({FIPS_KEY, FIPS_PT}, 0, 8, 0, ok);
    recv_block(FIPS_KEY, FIPS_PT, -1, got, fv, rl, os, ss, ok);
    checks++;
    if (!ok || got !== FIPS_CT) begin
      fails++;
      $display("[TB] FAIL midreset_data: got %h expected %h", got, FIPS_CT);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, rl, os, ss;
    int fv;
    logic [127:0] got, key, pt, exp;
    for (int f = 0; f < 4; f++) begin
      key = (f == 3) ? '0 : {$urandom, $urandom, $urandom, $urandom};
      pt  = (f == 3) ? '0 : {$urandom, $urandom, $urandom, $urandom};
      exp = aes_encrypt(key, pt);
      send_words({key, pt}, 0, 8, (f == 3) ? 2 : 0, ok);
      recv_block(key, pt, (f == 1) ? 2 : -1, got, fv, rl, os, ss, ok);
      checks++;
      if (!ok || got !== exp) begin
        fails++;
        $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", f, got, exp);
      end
      checks++;
      if (!os) begin fails++; $display("[TB] FAIL b2b_operands[%0d]: got core_key/core_mes changing expected stable", f); end
    end
    checks++;
    if (got !== ZERO_CT) begin fails++; $display("[TB] FAIL b2b_zero: got %h expected %h", got, ZERO_CT); end
  endtask

`ifdef AES_LOADER_KEY_REUSE_EN
  task automatic test_key_reuse();
    bit ok, rl, os, ss;
    int fv;
    logic [127:0] got;
    words_accepted = 0;
    send_words({FIPS_KEY, FIPS_PT}, 0, 8, 0, ok);
    key_keep = 1'b1;
    recv_block(FIPS_KEY, FIPS_PT, -1, got, fv, rl, os, ss, ok);
    key_keep = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reuse_state: got busy=%b in_ready=%b expected 1 1", busy, in_ready);
    end
    send_words({FIPS_KEY, FIPS_PT}, 4, 4, 1, ok);
    recv_block(FIPS_KEY, FIPS_PT, -1, got, fv, rl, os, ss, ok);
    checks++;
    if (!ok || got !== FIPS_CT) begin
      fails++;
      $display("[TB] FAIL reuse_data: got %h expected %h", got, FIPS_CT);
    end
    checks++;
    if (words_accepted != 12) begin
      fails++;
      $display("[TB] FAIL reuse_words: got %0d expected 12", words_accepted);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fips();
    test_stalls();
    test_mid_reset();
    test_back_to_back();
`ifdef AES_LOADER_KEY_REUSE_EN
    test_key_reuse();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
